// File: rtl/ex_operand_stage.sv
// Operand-select stage between decode and ALU: resolves forwarding at capture,
// holds one instruction, and stalls decode for one cycle on a load-use dependency.
module ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [XLEN-1:0] IN_PC,
  input  logic [XLEN-1:0] IN_RS1_DATA,
  input  logic [XLEN-1:0] IN_RS2_DATA,
  input  logic [XLEN-1:0] IN_IMM,
  input  logic [4:0]      IN_RS1,
  input  logic [4:0]      IN_RS2,
  input  logic [4:0]      IN_RD,
  input  logic [7:0]      IN_OPCODE,
  input  logic [6:0]      IN_FUNCT_SEVEN,
  input  logic [2:0]      IN_FUNCT_THREE,
  input  logic            FWD1_VALID,
  input  logic [4:0]      FWD1_RD,
  input  logic [XLEN-1:0] FWD1_DATA,
  input  logic            FWD2_VALID,
  input  logic [4:0]      FWD2_RD,
  input  logic [XLEN-1:0] FWD2_DATA,
  input  logic            FLUSH,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [7:0]      OPCODE,
  output logic [6:0]      FUNCT_SEVEN,
  output logic [2:0]      FUNCT_THREE,
  output logic [4:0]      OUT_RD,
  output logic [XLEN-1:0] OUT_STORE_DATA,
  output logic [XLEN-1:0] OUT_PC,
  output logic            OUT_IS_LOAD,
  output logic [15:0]     STALL_COUNT
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]      r_state;
  logic [XLEN-1:0] r_a, r_b, r_sd, r_pc;
  logic [7:0]      r_op;
  logic [6:0]      r_f7;
  logic [2:0]      r_f3;
  logic [4:0]      r_rd;
  logic            r_ld;
  logic [15:0]     r_stall;

  logic            w_use_rs1, w_use_rs2, w_hazard, w_xfer;
  logic [XLEN-1:0] w_rs1, w_rs2, w_a, w_b;

  // Newer (MEM) result wins over older (WB); x0 never forwards.
  function automatic logic [XLEN-1:0] resolve(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (rs == 5'd0)                        return '0;
    else if (FWD1_VALID && FWD1_RD == rs)  return FWD1_DATA;
    else if (FWD2_VALID && FWD2_RD == rs)  return FWD2_DATA;
    else                                   return rf;
  endfunction

  always_comb begin
    w_use_rs1 = !(IN_OPCODE == 8'h37 || IN_OPCODE == 8'h17 || IN_OPCODE == 8'h6F);
    w_use_rs2 = (IN_OPCODE == 8'h33 || IN_OPCODE == 8'h63 || IN_OPCODE == 8'h23);
    w_hazard  = (r_state == S_FULL) && r_ld && (r_rd != 5'd0) && IN_VALID &&
                ((w_use_rs1 && IN_RS1 == r_rd) || (w_use_rs2 && IN_RS2 == r_rd));
    IN_READY  = RST_N && ((r_state == S_EMPTY) || OUT_READY) && !w_hazard && !FLUSH;
    w_xfer    = IN_VALID && IN_READY;
    w_rs1     = resolve(IN_RS1, IN_RS1_DATA);
    w_rs2     = resolve(IN_RS2, IN_RS2_DATA);
    w_a       = w_rs1;
    if (IN_OPCODE == 8'h17 || IN_OPCODE == 8'h6F) w_a = IN_PC;
    else if (IN_OPCODE == 8'h37)                  w_a = '0;
    w_b       = (IN_OPCODE == 8'h33 || IN_OPCODE == 8'h63) ? w_rs2 : IN_IMM;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_EMPTY;
      r_a <= '0; r_b <= '0; r_sd <= '0; r_pc <= '0;
      r_op <= '0; r_f7 <= '0; r_f3 <= '0; r_rd <= '0; r_ld <= 1'b0;
      r_stall <= '0;
    end else begin
      if (w_hazard && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
      if (FLUSH) begin
        r_state <= S_EMPTY;
      end else if (w_xfer) begin
        r_state <= S_FULL;
        r_a  <= w_a;
        r_b  <= w_b;
        r_sd <= w_rs2;
        r_pc <= IN_PC;
        r_op <= IN_OPCODE;
        r_f7 <= IN_FUNCT_SEVEN;
        r_f3 <= IN_FUNCT_THREE;
        r_rd <= IN_RD;
        r_ld <= (IN_OPCODE == 8'h03);
      end else if (OUT_READY) begin
        r_state <= S_EMPTY;
      end
    end
  end

  // Data outputs keep their last values while EMPTY; OUT_VALID qualifies them.
  assign OUT_VALID      = (r_state == S_FULL);
  assign A              = r_a;
  assign B              = r_b;
  assign OPCODE         = r_op;
  assign FUNCT_SEVEN    = r_f7;
  assign FUNCT_THREE    = r_f3;
  assign OUT_RD         = r_rd;
  assign OUT_STORE_DATA = r_sd;
  assign OUT_PC         = r_pc;
  assign OUT_IS_LOAD    = r_ld;
  assign STALL_COUNT    = r_stall;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed scenarios, random traffic,
// mid-run reset and stall-counter saturation.
module tb_ex_operand_stage;

  logic        CLK, RST_N, IN_VALID, IN_READY, FWD1_VALID, FWD2_VALID, FLUSH;
  logic        OUT_VALID, OUT_READY, OUT_IS_LOAD;
  logic [31:0] IN_PC, IN_RS1_DATA, IN_RS2_DATA, IN_IMM, FWD1_DATA, FWD2_DATA;
  logic [31:0] A, B, OUT_STORE_DATA, OUT_PC;
  logic [4:0]  IN_RS1, IN_RS2, IN_RD, FWD1_RD, FWD2_RD, OUT_RD;
  logic [7:0]  IN_OPCODE, OPCODE;
  logic [6:0]  IN_FUNCT_SEVEN, FUNCT_SEVEN;
  logic [2:0]  IN_FUNCT_THREE, FUNCT_THREE;
  logic [15:0] STALL_COUNT;

  ex_operand_stage #(.XLEN(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_PC(IN_PC), .IN_RS1_DATA(IN_RS1_DATA), .IN_RS2_DATA(IN_RS2_DATA), .IN_IMM(IN_IMM),
    .IN_RS1(IN_RS1), .IN_RS2(IN_RS2), .IN_RD(IN_RD), .IN_OPCODE(IN_OPCODE),
    .IN_FUNCT_SEVEN(IN_FUNCT_SEVEN), .IN_FUNCT_THREE(IN_FUNCT_THREE),
    .FWD1_VALID(FWD1_VALID), .FWD1_RD(FWD1_RD), .FWD1_DATA(FWD1_DATA),
    .FWD2_VALID(FWD2_VALID), .FWD2_RD(FWD2_RD), .FWD2_DATA(FWD2_DATA),
    .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .A(A), .B(B), .OPCODE(OPCODE), .FUNCT_SEVEN(FUNCT_SEVEN), .FUNCT_THREE(FUNCT_THREE),
    .OUT_RD(OUT_RD), .OUT_STORE_DATA(OUT_STORE_DATA), .OUT_PC(OUT_PC),
    .OUT_IS_LOAD(OUT_IS_LOAD), .STALL_COUNT(STALL_COUNT)
  );

  typedef struct packed {
    logic [31:0] a, b;
    logic [7:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] sd, pc;
    logic        ld;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0;
  bit          m_full = 0, m_ld = 0, m_prev_rst = 1;
  logic [4:0]  m_rd = '0;
  int          m_stall = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return 0;
    if (FWD1_VALID && FWD1_RD == rs) return FWD1_DATA;
    if (FWD2_VALID && FWD2_RD == rs) return FWD2_DATA;
    return rf;
  endfunction

  function automatic exp_t expect_of();
    exp_t e;
    logic [31:0] r1 = fwd(IN_RS1, IN_RS1_DATA), r2 = fwd(IN_RS2, IN_RS2_DATA);
    case (IN_OPCODE)
      8'h17, 8'h6F: e.a = IN_PC;
      8'h37:        e.a = 0;
      default:      e.a = r1;
    endcase
    e.b  = (IN_OPCODE inside {8'h33, 8'h63}) ? r2 : IN_IMM;
    e.op = IN_OPCODE; e.f7 = IN_FUNCT_SEVEN; e.f3 = IN_FUNCT_THREE;
    e.rd = IN_RD; e.sd = r2; e.pc = IN_PC; e.ld = (IN_OPCODE == 8'h03);
    return e;
  endfunction

  // Monitor: pops one expected transaction per ALU-side handshake.
  always @(negedge CLK) begin
    if (!RST_N) sb.delete();
    else begin
      chk("out_valid", {159'd0, OUT_VALID}, {159'd0, sb.size() != 0});
      if (FLUSH) sb.delete();
      else if (OUT_VALID && OUT_READY) begin
        if (sb.size() == 0) chk("unexpected_out", 160'd1, 160'd0);
        else chk("out_txn", {8'd0, A, B, OPCODE, FUNCT_SEVEN, FUNCT_THREE, OUT_RD,
                             OUT_STORE_DATA, OUT_PC, OUT_IS_LOAD}, {8'd0, sb.pop_front()});
      end
    end
  end

  // Reference rules applied just before each edge; pushes accepted instructions.
  task automatic model_update();
    bit hz, rdy;
    if (m_prev_rst)
      chk("reset_outputs", {OUT_VALID, A, B, OPCODE, FUNCT_SEVEN, FUNCT_THREE, OUT_RD,
                            OUT_STORE_DATA, OUT_PC, OUT_IS_LOAD, STALL_COUNT}, 160'd0);
    m_prev_rst = !RST_N;
    if (!RST_N) begin
      chk("in_ready_rst", {159'd0, IN_READY}, 160'd0);
      m_full = 0; m_stall = 0;
      return;
    end
    chk("stall_count", {144'd0, STALL_COUNT}, 160'(m_stall));
    hz = m_full && m_ld && m_rd != 0 && IN_VALID &&
         ((!(IN_OPCODE inside {8'h37, 8'h17, 8'h6F}) && IN_RS1 == m_rd) ||
          ((IN_OPCODE inside {8'h33, 8'h63, 8'h23}) && IN_RS2 == m_rd));
    rdy = (!m_full || OUT_READY) && !hz && !FLUSH;
    chk("in_ready", {159'd0, IN_READY}, {159'd0, rdy});
    if (hz && m_stall < 16'hFFFF) m_stall++;
    if (FLUSH) m_full = 0;
    else if (IN_VALID && rdy) begin
      sb.push_back(expect_of());
      m_full = 1; m_ld = (IN_OPCODE == 8'h03); m_rd = IN_RD;
    end else if (OUT_READY) m_full = 0;
  endtask

  task automatic cyc();
    @(negedge CLK); #1 model_update();
    @(posedge CLK); #1;
  endtask

  task automatic set_in(input logic v, input logic [7:0] op, input logic [4:0] rd, rs1, rs2,
                        input logic [31:0] d1, d2, imm, pc);
    IN_VALID = v; IN_OPCODE = op; IN_RD = rd; IN_RS1 = rs1; IN_RS2 = rs2;
    IN_RS1_DATA = d1; IN_RS2_DATA = d2; IN_IMM = imm; IN_PC = pc;
    IN_FUNCT_SEVEN = 7'(op); IN_FUNCT_THREE = 3'(rd);
  endtask

  task automatic set_fwd(input logic v1, input logic [4:0] r1, input logic [31:0] x1,
                         input logic v2, input logic [4:0] r2, input logic [31:0] x2);
    FWD1_VALID = v1; FWD1_RD = r1; FWD1_DATA = x1;
    FWD2_VALID = v2; FWD2_RD = r2; FWD2_DATA = x2;
  endtask

  logic [7:0] ops [9] = '{8'h13, 8'h33, 8'h63, 8'h23, 8'h03, 8'h37, 8'h17, 8'h6F, 8'h67};

  initial begin
    RST_N = 0; FLUSH = 0; OUT_READY = 1;
    set_in(0, 8'h13, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    RST_N = 1; cyc();
    // ADDI, then ADD with both forwarding sources on x1
    set_in(1, 8'h13, 1, 2, 0, 10, 0, 5, 32'h40); cyc();
    set_fwd(1, 1, 7, 1, 1, 9);
    set_in(1, 8'h33, 3, 1, 1, 1, 1, 0, 32'h44); cyc();
    set_fwd(0, 0, 0, 0, 0, 0);
    // LW x5 then dependent ADD: one bubble, one stall
    set_in(1, 8'h03, 5, 2, 0, 32'h1000, 0, 4, 32'h48); cyc();
    set_in(1, 8'h33, 6, 5, 0, 3, 4, 0, 32'h4C); cyc(); cyc();
    // x0 never forwards
    set_fwd(1, 0, 32'hDEAD, 0, 0, 0);
    set_in(1, 8'h13, 7, 0, 0, 32'h55, 0, 1, 32'h50); cyc();
    set_fwd(0, 0, 0, 0, 0, 0);
    set_in(1, 8'h17, 8, 3, 0, 32'h77, 0, 32'h2000, 32'h100); cyc();
    set_in(1, 8'h37, 9, 3, 0, 32'h77, 0, 32'h3000, 32'h104); cyc();
    // hold with OUT_READY low, flush in the second held cycle
    set_in(1, 8'h13, 10, 1, 0, 1, 0, 2, 32'h108); cyc();
    OUT_READY = 0;
    set_in(1, 8'h13, 11, 1, 0, 5, 0, 6, 32'h10C); cyc();
    FLUSH = 1; cyc();
    FLUSH = 0; cyc();
    OUT_READY = 1; set_in(0, 8'h13, 0, 0, 0, 0, 0, 0, 0); cyc();

    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 3) != 0, ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom,
             $urandom, $urandom);
      set_fwd($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom);
      OUT_READY = $urandom_range(0, 3) != 0;
      FLUSH     = $urandom_range(0, 15) == 0;
      cyc();
    end
    FLUSH = 0; OUT_READY = 1; set_fwd(0, 0, 0, 0, 0, 0);
    set_in(0, 8'h13, 0, 0, 0, 0, 0, 0, 0); cyc();

    // mid-run reset while holding a load
    OUT_READY = 0; set_in(1, 8'h03, 5, 1, 0, 8, 0, 0, 32'h200); cyc();
    RST_N = 0; OUT_READY = 1; set_in(1, 8'h13, 4, 1, 0, 2, 0, 3, 32'h204); cyc();
    RST_N = 1; set_in(0, 8'h13, 0, 0, 0, 0, 0, 0, 0); cyc();

    // stall counter saturation: dependent instruction waits behind a held load
    OUT_READY = 1; set_in(1, 8'h03, 5, 1, 0, 8, 0, 0, 32'h300); cyc();
    OUT_READY = 0; set_in(1, 8'h23, 0, 0, 5, 0, 9, 0, 32'h304);
    for (int i = 0; i < 65540; i++) cyc();
    chk("stall_sat", {144'd0, STALL_COUNT}, {144'd0, 16'hFFFF});
    OUT_READY = 1; cyc(); cyc();
    set_in(0, 8'h13, 0, 0, 0, 0, 0, 0, 0); cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST_N  in  1  synchronous, active-low reset, sampled on rising CLK.
REQ-004 IN_VALID  in  1 / IN_READY  out  1: decode-side handshake; transfer occurs when both are 1.
REQ-005 IN_PC, IN_RS1_DATA, IN_RS2_DATA, IN_IMM  in  32 each: PC, register-file read data, sign-extended immediate.
REQ-006 IN_RS1, IN_RS2, IN_RD  in  5 each: source and destination register indices.
REQ-007 IN_OPCODE  in  8 ({1'b0, instr[6:0]}); IN_FUNCT_SEVEN  in  7; IN_FUNCT_THREE  in  3.
REQ-008 FWD1_VALID  in  1, FWD1_RD  in  5, FWD1_DATA  in  32: newer forwarding source (MEM-stage result).
REQ-009 FWD2_VALID  in  1, FWD2_RD  in  5, FWD2_DATA  in  32: older forwarding source (writeback result).
REQ-010 FLUSH  in  1: discards the held instruction and any input offered that cycle.
REQ-011 OUT_VALID  out  1 / OUT_READY  in  1: ALU-side handshake.
REQ-012 A, B  out  32: ALU operands; OPCODE  out  8; FUNCT_SEVEN  out  7; FUNCT_THREE  out  3: registered copies for the ALU.
REQ-013 OUT_RD  out  5, OUT_STORE_DATA  out  32, OUT_PC  out  32, OUT_IS_LOAD  out  1 (OPCODE == 8'h03).
REQ-014 STALL_COUNT  out  16: load-use stall cycle counter.

Function
REQ-015 The block SHALL be a single registered stage with FSM states EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
REQ-016 Rs1 use SHALL be defined as OPCODE not in {8'h37 LUI, 8'h17 AUIPC, 8'h6F JAL}; rs2 use SHALL be defined as OPCODE in {8'h33, 8'h63, 8'h23}.
REQ-017 A load-use hazard SHALL be defined as: FULL, OUT_IS_LOAD=1, OUT_RD!=0, IN_VALID=1, and OUT_RD equals a used IN_RS1/IN_RS2.
REQ-018 IN_READY SHALL equal (EMPTY or OUT_READY) and not hazard and not FLUSH.
REQ-019 On a transfer, all outputs SHALL load from the input in the same edge, giving a latency of 1 cycle from acceptance to OUT_VALID=1.
REQ-020 Resolved rs value SHALL be: FWD1_DATA if FWD1_VALID and FWD1_RD==rs and rs!=0; else FWD2_DATA if the same test passes for FWD2; else IN_RSx_DATA; x0 SHALL always resolve to 0.
REQ-021 A SHALL be IN_PC for AUIPC/JAL, 0 for LUI, and resolved rs1 otherwise.
REQ-022 B SHALL be resolved rs2 for 8'h33/8'h63, and IN_IMM otherwise.
REQ-023 OUT_STORE_DATA SHALL be resolved rs2.
REQ-024 Forwarding SHALL be evaluated only at capture; held outputs SHALL NOT change while FULL and OUT_READY=0.
REQ-025 When FULL, OUT_READY=1, and no new transfer occurs, the state SHALL go to EMPTY; a hazard SHALL therefore insert exactly one bubble.
REQ-026 When FULL, OUT_READY=1, and a transfer occurs, the state SHALL remain FULL with the new instruction (back-to-back, no bubble).
REQ-027 FLUSH=1 SHALL force EMPTY next cycle regardless of handshakes, and SHALL take priority over capture and hazard.
REQ-028 STALL_COUNT SHALL increment by 1 on each cycle a hazard is asserted, and SHALL saturate at 16'hFFFF.
REQ-029 When EMPTY, data outputs SHALL hold their last values, and consumers SHALL qualify them with OUT_VALID.

Reset
REQ-030 When RST_N=0 at an edge, the block SHALL enter EMPTY, and all outputs SHALL be 0, including STALL_COUNT.
REQ-031 IN_READY SHALL be 0 while RST_N=0.
REQ-032 Reset mid-operation SHALL discard the held instruction, and no output transfer SHALL occur that cycle.

Verification
REQ-033 Scenario: ADDI x1,x2,5 (IN_OPCODE 8'h13, RS1=2, RS1_DATA=10, IMM=5), no forwarding -> next cycle OUT_VALID=1, A=10, B=5.
REQ-034 Scenario: ADD x3,x1,x1 with FWD1 (RD=1, DATA=7) and FWD2 (RD=1, DATA=9) both valid -> A=7, B=7 (FWD1 priority).
REQ-035 Scenario: LW x5 held in FULL, next input ADD x6,x5,x0 -> IN_READY=0 for 1 cycle, one bubble (OUT_VALID=0), STALL_COUNT=1, then the ADD is captured.
REQ-036 Scenario: FWD1_RD=0, FWD1_DATA=32'hDEAD, and instruction uses rs1=x0 -> A=0.
REQ-037 Scenario: FULL with OUT_READY=0 for 3 cycles -> outputs stable, IN_READY=0; FLUSH in cycle 2 -> EMPTY next cycle.
REQ-038 Scenario: AUIPC with IN_PC=32'h100, IMM=32'h2000 -> A=32'h100, B=32'h2000; LUI -> A=0.
